// File: rtl/request_unit.sv
// request_unit
// Memory-side consumer of decoded dREN/dWEN/halt/LL/SC controls. Converts a
// single-cycle instruction decode into a data-memory request that is held
// stable until the cache answers with dhit, gates PC advance, latches a sticky
// halt and, when LLSC_EN is defined, keeps an LL/SC link register that is
// invalidated by matching snoops.
//
// Optional feature macro: LLSC_EN (undefined: LL acts as LW, SC acts as SW,
// snoop inputs are ignored and no link state exists).
//
// Ports
//   CLK, RST      clock (rising edge), asynchronous active-high reset
//   ihit          instruction fetch valid this cycle
//   dhit          data access complete (one-cycle pulse)
//   dREN_in       decoded load (LW/LL)
//   dWEN_in       decoded store (SW/SC)
//   ll_in, sc_in  decoded LL / SC
//   halt_in       decoded HALT
//   daddr_in      byte address of the data access
//   dstore_in     store data
//   snoop_valid   another agent wrote snoop_addr
//   snoop_addr    snooped byte address
//   imemREN       instruction read enable
//   dmemREN/WEN   held data read / write request
//   dmemaddr      held word address (bits [1:0] are zero)
//   dmemstore     held store data
//   pc_en         advance PC this cycle
//   sc_result     SC success flag, valid with the pc_en that completes an SC
//   halt          sticky halt
//   wait_cnt      cycles spent waiting for dhit on the current request
module request_unit #(
  parameter int WAIT_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic              ll_in,
  input  logic              sc_in,
  input  logic              halt_in,
  input  logic [31:0]       daddr_in,
  input  logic [31:0]       dstore_in,
  input  logic              snoop_valid,
  input  logic [31:0]       snoop_addr,
  output logic              imemREN,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [31:0]       dmemaddr,
  output logic [31:0]       dmemstore,
  output logic              pc_en,
  output logic              sc_result,
  output logic              halt,
  output logic [WAIT_W-1:0] wait_cnt
);

  typedef enum logic [1:0] {IDLE, DREQ, HALTED} state_t;

  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v == WAIT_MAX) ? v : v + 1'b1;
  endfunction

  state_t      state, state_next;
  logic        accept;
  logic        sc_fail;
  logic        req_ren, req_wen, req_sc, req_ll;
  logic [29:0] req_addr;
  logic [31:0] req_store;
  logic        complete;
  logic        link_match;

`ifdef LLSC_EN
  logic        link_valid;
  logic [29:0] link_addr;
  logic        unused_bits;

  assign unused_bits = ^{daddr_in[1:0], snoop_addr[1:0]};
  assign link_match  = link_valid && (daddr_in[31:2] == link_addr);
`else
  logic        unused_inputs;

  assign unused_inputs = ^{daddr_in[1:0], snoop_valid, snoop_addr};
  assign link_match    = 1'b1;
`endif

  assign complete = (state == DREQ) && dhit;

  // Next-state and combinational outputs
  always_comb begin
    state_next = state;
    pc_en      = 1'b0;
    sc_result  = 1'b0;
    accept     = 1'b0;
    sc_fail    = 1'b0;
    case (state)
      IDLE: begin
        if (ihit) begin
          if (halt_in) begin
            state_next = HALTED;
          end else if (dREN_in || dWEN_in) begin
            // An SC without a matching link never reaches memory: it
            // retires immediately as a failed SC.
            if (sc_in && !link_match) begin
              pc_en   = 1'b1;
              sc_fail = 1'b1;
            end else begin
              accept     = 1'b1;
              state_next = DREQ;
            end
          end else begin
            pc_en = 1'b1;
          end
        end
      end
      DREQ: begin
        if (dhit) begin
          pc_en      = 1'b1;
          sc_result  = req_sc;
          state_next = IDLE;
        end
      end
      HALTED: state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Held request: captured on accept, flags dropped on completion
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_ren   <= 1'b0;
      req_wen   <= 1'b0;
      req_sc    <= 1'b0;
      req_ll    <= 1'b0;
      req_addr  <= '0;
      req_store <= '0;
    end else if (accept) begin
      req_wen   <= dWEN_in;
      req_ren   <= dREN_in && !dWEN_in;
      req_sc    <= sc_in;
      req_ll    <= ll_in && !dWEN_in;
      req_addr  <= daddr_in[31:2];
      req_store <= dstore_in;
    end else if (complete) begin
      req_ren <= 1'b0;
      req_wen <= 1'b0;
      req_sc  <= 1'b0;
      req_ll  <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                        wait_cnt <= '0;
    else if (state == DREQ && !dhit) wait_cnt <= sat_inc(wait_cnt);
    else                            wait_cnt <= '0;
  end

`ifdef LLSC_EN
  // Link register; a snoop coinciding with the LL completion is checked
  // against the address being linked, so the snoop wins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (complete && req_ll) begin
      link_addr  <= req_addr;
      link_valid <= !(snoop_valid && (snoop_addr[31:2] == req_addr));
    end else if ((complete && req_sc) || sc_fail ||
                 (snoop_valid && (snoop_addr[31:2] == link_addr))) begin
      link_valid <= 1'b0;
    end
  end
`else
  logic unused_ctl;
  assign unused_ctl = ^{req_ll, sc_fail};
`endif

  assign imemREN   = (state == IDLE);
  assign halt      = (state == HALTED);
  assign dmemREN   = req_ren;
  assign dmemWEN   = req_wen;
  assign dmemaddr  = {req_addr, 2'b00};
  assign dmemstore = req_store;

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit: random and directed instruction
// streams feed a queue of expected requests and PC-advance events; a monitor
// on the falling edge compares whatever the DUT presents against them.
module tb_request_unit;
  localparam int WAIT_W = 8;
  localparam int WMAX   = (1 << WAIT_W) - 1;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              ihit = 1'b0, dhit = 1'b0;
  logic              dREN_in = 1'b0, dWEN_in = 1'b0, ll_in = 1'b0, sc_in = 1'b0;
  logic              halt_in = 1'b0;
  logic [31:0]       daddr_in = '0, dstore_in = '0;
  logic              snoop_valid = 1'b0;
  logic [31:0]       snoop_addr = '0;
  logic              imemREN, dmemREN, dmemWEN, pc_en, sc_result, halt;
  logic [31:0]       dmemaddr, dmemstore;
  logic [WAIT_W-1:0] wait_cnt;

  request_unit #(.WAIT_W(WAIT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dREN_in(dREN_in), .dWEN_in(dWEN_in), .ll_in(ll_in), .sc_in(sc_in),
    .halt_in(halt_in), .daddr_in(daddr_in), .dstore_in(dstore_in),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .pc_en(pc_en),
    .sc_result(sc_result), .halt(halt), .wait_cnt(wait_cnt)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
  } req_t;

  req_t req_q[$];
  bit   done_q[$];
  bit   mon_en = 1'b0;
  bit   was_active = 1'b0;
  req_t cur;
  int   k = 0;
  bit   exp_sc;

  // Reference link state (only meaningful with LLSC_EN)
  bit          link_v = 1'b0;
  logic [29:0] link_a = '0;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (dmemREN || dmemWEN) begin
        if (!was_active) begin
          k = 0;
          if (req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got ren=%0b wen=%0b addr=0x%0h, expected none",
                     dmemREN, dmemWEN, dmemaddr);
            cur = '{ren: dmemREN, wen: dmemWEN, addr: dmemaddr, store: dmemstore};
          end else begin
            cur = req_q.pop_front();
          end
        end
        check("dmemREN", dmemREN, cur.ren);
        check("dmemWEN", dmemWEN, cur.wen);
        check("dmemaddr", dmemaddr, cur.addr);
        check("dmemstore", dmemstore, cur.store);
        check("wait_cnt", wait_cnt, (k > WMAX) ? WMAX : k);
        k++;
      end else begin
        check("wait_cnt_idle", wait_cnt, 0);
      end
      if (pc_en) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pc_en: got pc_en=1, expected 0");
        end else begin
          exp_sc = done_q.pop_front();
          check("sc_result", sc_result, exp_sc);
        end
      end
      was_active = dmemREN || dmemWEN;
    end
  end

  task automatic clear_inputs();
    ihit = 0; dhit = 0; dREN_in = 0; dWEN_in = 0; ll_in = 0; sc_in = 0;
    halt_in = 0; snoop_valid = 0;
  endtask

  // One instruction from decode through completion; expectations are pushed
  // from the instruction's meaning, not from any DUT state.
  task automatic issue(input bit ren, input bit wen, input bit ll, input bit sc,
                       input logic [31:0] addr, input logic [31:0] st,
                       input int hold, input bit snoop_at_dhit);
    bit   go;
    req_t r;
    @(posedge CLK); #1;
    ihit = 1; dREN_in = ren; dWEN_in = wen; ll_in = ll; sc_in = sc;
    daddr_in = addr; dstore_in = st;
    go = ren | wen;
`ifdef LLSC_EN
    if (sc && go && !(link_v && addr[31:2] == link_a)) begin
      go = 0;
      link_v = 0;
    end
`endif
    if (go) begin
      r.ren = ren & ~wen; r.wen = wen; r.addr = {addr[31:2], 2'b00}; r.store = st;
      req_q.push_back(r);
      done_q.push_back(sc);
    end else begin
      done_q.push_back(1'b0);
    end
    @(posedge CLK); #1;
    clear_inputs();
    if (go) begin
      // Decode noise while waiting must be ignored.
      ihit = 1'($urandom); dREN_in = 1'($urandom); dWEN_in = 1'($urandom);
      sc_in = 1'($urandom); daddr_in = $urandom; dstore_in = $urandom;
      repeat (hold) begin @(posedge CLK); #1; end
      dhit = 1;
      snoop_valid = snoop_at_dhit;
      snoop_addr = addr;
      @(posedge CLK); #1;
`ifdef LLSC_EN
      if (ll && !wen) begin link_v = !snoop_at_dhit; link_a = addr[31:2]; end
      if (sc) link_v = 0;
`endif
      clear_inputs();
    end
  endtask

`ifdef LLSC_EN
  task automatic snoop(input logic [31:0] a);
    @(posedge CLK); #1;
    snoop_valid = 1; snoop_addr = a;
    @(posedge CLK); #1;
    snoop_valid = 0;
    if (link_v && a[31:2] == link_a) link_v = 0;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int          kind;
    logic [31:0] last_ll;
    logic [31:0] a;
    last_ll = 32'h100;

    repeat (2) @(posedge CLK);
    #1;
    check("rst_imemREN", imemREN, 1);
    check("rst_dmemREN", dmemREN, 0);
    check("rst_dmemWEN", dmemWEN, 0);
    check("rst_dmemaddr", dmemaddr, 0);
    check("rst_dmemstore", dmemstore, 0);
    check("rst_pc_en", pc_en, 0);
    check("rst_sc_result", sc_result, 0);
    check("rst_halt", halt, 0);
    check("rst_wait_cnt", wait_cnt, 0);
    @(negedge CLK);
    RST = 0;
    mon_en = 1;

    issue(1, 0, 0, 0, 32'h0000_1007, 32'h0, 5, 0);
    issue(1, 1, 0, 0, 32'h0000_2000, 32'hDEAD_BEEF, 3, 0);
    issue(0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    issue(0, 1, 0, 0, 32'h0000_0040, 32'h0000_0055, 300, 0);
    issue(1, 0, 0, 0, 32'h0000_0080, 32'h0, 0, 0);
    issue(1, 0, 1, 0, 32'h0000_0100, 32'h0, 1, 0);
    issue(0, 1, 0, 1, 32'h0000_0100, 32'h0000_0077, 2, 0);
`ifdef LLSC_EN
    issue(1, 0, 1, 0, 32'h0000_0100, 32'h0, 1, 0);
    snoop(32'h0000_0100);
    issue(0, 1, 0, 1, 32'h0000_0100, 32'h0000_0011, 1, 0);
    issue(1, 0, 1, 0, 32'h0000_0100, 32'h0, 2, 1);
    issue(0, 1, 0, 1, 32'h0000_0100, 32'h0000_0022, 1, 0);
    issue(1, 0, 1, 0, 32'h0000_0100, 32'h0, 0, 0);
    snoop(32'h0000_0200);
    issue(0, 1, 0, 1, 32'h0000_0103, 32'h0000_0033, 1, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      a = $urandom;
      if (kind == 4 && ($urandom % 2) == 1) a = last_ll;
      if (kind == 3) last_ll = a;
      case (kind)
        0: issue(1, 0, 0, 0, a, $urandom, $urandom_range(0, 6), 0);
        1: issue(0, 1, 0, 0, a, $urandom, $urandom_range(0, 6), 0);
        2: issue(1, 1, 0, 0, a, $urandom, $urandom_range(0, 6), 0);
        3: issue(1, 0, 1, 0, a, $urandom, $urandom_range(0, 6), 0);
        4: issue(0, 1, 0, 1, a, $urandom, $urandom_range(0, 6), 0);
        default: issue(0, 0, 0, 0, a, $urandom, 0, 0);
      endcase
    end

    repeat (2) @(posedge CLK);
    #1;
    check("req_q_left", req_q.size(), 0);
    check("done_q_left", done_q.size(), 0);
    mon_en = 0;

    // Asynchronous reset in the middle of a held store
    ihit = 1; dWEN_in = 1; daddr_in = 32'h500; dstore_in = 32'h1234;
    @(posedge CLK); #1;
    clear_inputs();
    check("mid_dmemWEN", dmemWEN, 1);
    repeat (2) begin @(posedge CLK); #1; end
    RST = 1;
    #1;
    check("rst_mid_dmemWEN", dmemWEN, 0);
    check("rst_mid_imemREN", imemREN, 1);
    check("rst_mid_wait_cnt", wait_cnt, 0);
    @(posedge CLK); #1;
    RST = 0;
    @(posedge CLK); #1;
    ihit = 1;
    #1;
    check("post_rst_pc_en", pc_en, 1);
    check("post_rst_dmemWEN", dmemWEN, 0);
    @(posedge CLK); #1;
    ihit = 0;

    // Halt is sticky
    @(posedge CLK); #1;
    ihit = 1; halt_in = 1;
    @(posedge CLK); #1;
    halt_in = 0;
    for (int i = 0; i < 4; i++) begin
      ihit = 1; dREN_in = 1; daddr_in = 32'h900;
      #1;
      check("halt", halt, 1);
      check("halt_imemREN", imemREN, 0);
      check("halt_pc_en", pc_en, 0);
      check("halt_dmemREN", dmemREN, 0);
      @(posedge CLK); #1;
    end
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
